// File: rtl/ir_transmitter.sv
// rtl/ir_transmitter.sv - NEC infrared transmitter with carrier modulation
// Segment FSM paced by a unit counter; the envelope is gated by a local carrier.
module ir_transmitter #(
   parameter int UNIT_CYCLES  = 56250,
   parameter int CARRIER_HALF = 1316
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] code_in,
   input  logic        send_in,
   input  logic        repeat_in,
   output logic        ir_out,
   output logic        envelope_out,
   output logic        busy_out,
   output logic        done_out,
   output logic [2:0]  state_out
);

   localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
   localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
   localparam logic [UW-1:0] UNIT_INC  = UW'(1);
   localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_HALF - 1);
   localparam logic [CW-1:0] CAR_INC   = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LEAD_MARK  = 3'd1,
      S_LEAD_SPACE = 3'd2,
      S_BIT_MARK   = 3'd3,
      S_BIT_SPACE  = 3'd4,
      S_STOP_MARK  = 3'd5
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [UW-1:0] r_unit_cnt;
   logic [4:0]    r_seg_cnt;
   logic [5:0]    r_bit_cnt;
   logic [31:0]   r_shift;
   logic          r_is_repeat;
   logic [CW-1:0] r_phase;
   logic          r_carrier;
   logic          r_done;

   logic [4:0]    w_seg_last;
   logic          w_unit_tick;
   logic          w_seg_end;
   logic          w_start_send;
   logic          w_start_rpt;
   logic          w_transition;
   logic          w_next_is_mark;
   logic          w_mark_entry;

   // Segment length in units, minus one; a data bit's space length follows the MSB.
   always_comb begin
      w_seg_last = 5'd0;
      case (r_state)
         S_LEAD_MARK:  w_seg_last = 5'd15;
         S_LEAD_SPACE: w_seg_last = r_is_repeat ? 5'd3 : 5'd7;
         S_BIT_SPACE:  w_seg_last = r_shift[31] ? 5'd2 : 5'd0;
         default:      w_seg_last = 5'd0;
      endcase
   end

   assign w_unit_tick  = (r_unit_cnt == UNIT_LAST);
   assign w_seg_end    = w_unit_tick && (r_seg_cnt == w_seg_last);
   assign w_start_send = (r_state == S_IDLE) && send_in;
   assign w_start_rpt  = (r_state == S_IDLE) && !send_in && repeat_in;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:       if (send_in || repeat_in) w_next_state = S_LEAD_MARK;
         S_LEAD_MARK:  if (w_seg_end) w_next_state = S_LEAD_SPACE;
         S_LEAD_SPACE: if (w_seg_end) w_next_state = r_is_repeat ? S_STOP_MARK : S_BIT_MARK;
         S_BIT_MARK:   if (w_seg_end) w_next_state = S_BIT_SPACE;
         S_BIT_SPACE:  if (w_seg_end) w_next_state = (r_bit_cnt < 6'd31) ? S_BIT_MARK : S_STOP_MARK;
         S_STOP_MARK:  if (w_seg_end) w_next_state = S_IDLE;
         default:      w_next_state = S_IDLE;
      endcase
   end

   assign w_transition   = (w_next_state != r_state);
   assign w_next_is_mark = (w_next_state == S_LEAD_MARK) || (w_next_state == S_BIT_MARK) ||
                           (w_next_state == S_STOP_MARK);
   assign w_mark_entry   = w_transition && w_next_is_mark;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state     <= S_IDLE;
         r_unit_cnt  <= '0;
         r_seg_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_is_repeat <= 1'b0;
         r_phase     <= '0;
         r_carrier   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_done  <= (r_state == S_STOP_MARK) && w_seg_end;

         if (w_transition || (r_state == S_IDLE)) begin
            r_unit_cnt <= '0;
            r_seg_cnt  <= '0;
         end else if (w_unit_tick) begin
            r_unit_cnt <= '0;
            r_seg_cnt  <= r_seg_cnt + 5'd1;
         end else begin
            r_unit_cnt <= r_unit_cnt + UNIT_INC;
         end

         if (w_start_send) begin
            r_shift     <= code_in;
            r_is_repeat <= 1'b0;
            r_bit_cnt   <= '0;
         end else if (w_start_rpt) begin
            r_is_repeat <= 1'b1;
            r_bit_cnt   <= '0;
         end else if ((r_state == S_BIT_SPACE) && w_seg_end) begin
            r_shift   <= {r_shift[30:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 6'd1;
         end

         // Carrier restarts high on every mark so each burst begins with a lit LED.
         if (w_mark_entry) begin
            r_phase   <= '0;
            r_carrier <= 1'b1;
         end else if (w_next_is_mark) begin
            if (r_phase == CAR_LAST) begin
               r_phase   <= '0;
               r_carrier <= ~r_carrier;
            end else begin
               r_phase <= r_phase + CAR_INC;
            end
         end else begin
            r_phase   <= '0;
            r_carrier <= 1'b0;
         end
      end
   end

   assign envelope_out = (r_state == S_LEAD_MARK) || (r_state == S_BIT_MARK) ||
                         (r_state == S_STOP_MARK);
   assign ir_out       = envelope_out && r_carrier;
   assign busy_out     = (r_state != S_IDLE);
   assign done_out     = r_done;
   assign state_out    = r_state;

endmodule
